reorder_buffer: RTL and testbench

//  In-order retirement buffer that sits between dispatch, the CDB and the register file.

---
 rtl/reorder_buffer.sv | 112 +++++++++++
 tb/tb_reorder_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer between dispatch, the CDB and the register file.
// Optional macro ROB_BYPASS_EN: a CDB result for the head entry commits in the same cycle.
module reorder_buffer #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alloc_valid,
   input  logic [REG_AW-1:0] alloc_dest,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              commit_en,
   output logic [REG_AW-1:0] commit_reg,
   output logic [DATA_W-1:0] commit_data,
   output logic              rob_empty,
   output logic              rob_full,
   output logic [TAG_W:0]    rob_count
);

   localparam int unsigned PTR_W = TAG_W + 1;

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]  valid_q, valid_d, ready_q, ready_d;
   logic [REG_AW-1:0] dest_q [DEPTH];
   logic [REG_AW-1:0] dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [TAG_W-1:0]  head_idx, tail_idx;
   logic              alloc_fire;

   assign head_idx    = head_q[TAG_W-1:0];
   assign tail_idx    = tail_q[TAG_W-1:0];
   assign rob_full    = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
   assign rob_empty   = (head_q == tail_q);
   assign rob_count   = tail_q - head_q;
   assign alloc_ready = !rob_full;
   assign alloc_tag   = tail_idx;
   assign alloc_fire  = alloc_valid && !rob_full;

   // Commit port: driven straight from the head entry, suppressed during a flush.
   always_comb begin
      commit_en   = valid_q[head_idx] && ready_q[head_idx] && !flush;
      commit_reg  = dest_q[head_idx];
      commit_data = data_q[head_idx];
`ifdef ROB_BYPASS_EN
      if (wb_valid && (wb_tag == head_idx) && valid_q[head_idx] && !flush) begin
         commit_en   = 1'b1;
         commit_data = wb_data;
      end
`endif
   end

   // Entry/pointer update; commit is applied after writeback so a bypassed head still retires.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      ready_d = ready_q;
      dest_d  = dest_q;
      data_d  = data_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         valid_d = '0;
         ready_d = '0;
      end else begin
         if (wb_valid && valid_q[wb_tag]) begin
            ready_d[wb_tag] = 1'b1;
            data_d[wb_tag]  = wb_data;
         end
         if (commit_en) begin
            valid_d[head_idx] = 1'b0;
            ready_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
         end
         if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            ready_d[tail_idx] = 1'b0;
            dest_d[tail_idx]  = alloc_dest;
            tail_d            = tail_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         ready_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            dest_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         dest_q  <= dest_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: queue-based reference model of the ROB plus a negedge monitor that
// compares every output against it; directed scenarios followed by randomized traffic.
module tb_reorder_buffer;
   localparam int unsigned DEPTH = 8, TAG_W = 3, DATA_W = 16, REG_AW = 5;
`ifdef ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0, reset_n = 1'b0;
   logic              alloc_valid = 1'b0, wb_valid = 1'b0, flush = 1'b0;
   logic [REG_AW-1:0] alloc_dest = '0;
   logic [TAG_W-1:0]  wb_tag = '0;
   logic [DATA_W-1:0] wb_data = '0;
   logic              alloc_ready, commit_en, rob_empty, rob_full;
   logic [TAG_W-1:0]  alloc_tag;
   logic [REG_AW-1:0] commit_reg;
   logic [DATA_W-1:0] commit_data;
   logic [TAG_W:0]    rob_count;

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .reset_n(reset_n), .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
      .wb_data(wb_data), .flush(flush), .commit_en(commit_en), .commit_reg(commit_reg),
      .commit_data(commit_data), .rob_empty(rob_empty), .rob_full(rob_full), .rob_count(rob_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] data;
      bit                ready;
   } ent_t;
   typedef struct {
      logic [REG_AW-1:0] r;
      logic [DATA_W-1:0] d;
   } cm_t;

   ent_t        m[$];       // in-flight instructions, program order
   int unsigned m_tail = 0; // total accepted allocs since last reset/flush
   cm_t         log_q[$];   // commits observed on the DUT port
   int          checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit byp_hit();
`ifdef ROB_BYPASS_EN
      return reset_n && !flush && wb_valid && (m.size() > 0) && (wb_tag == m[0].tag);
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: applies the retirement rules at each edge.
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n || flush) begin
         m.delete();
         m_tail = 0;
      end else begin
         bit full_pre, com;
         full_pre = (m.size() == DEPTH);
         com      = (m.size() > 0) && (m[0].ready || byp_hit());
         if (wb_valid)
            foreach (m[i]) if (m[i].tag == wb_tag) begin
               m[i].ready = 1'b1;
               m[i].data  = wb_data;
            end
         if (com) void'(m.pop_front());
         if (alloc_valid && !full_pre) begin
            m.push_back('{tag: TAG_W'(m_tail % DEPTH), dest: alloc_dest, data: '0, ready: 1'b0});
            m_tail++;
         end
      end
   end

   // Monitor: compares DUT outputs with the model every cycle, logs commits.
   initial forever begin
      bit                ec;
      logic [DATA_W-1:0] ed;
      @(negedge clk);
      chk("rob_count", 32'(rob_count), 32'(m.size()));
      chk("rob_full", 32'(rob_full), 32'(m.size() == DEPTH));
      chk("rob_empty", 32'(rob_empty), 32'(m.size() == 0));
      chk("alloc_ready", 32'(alloc_ready), 32'(m.size() != DEPTH));
      chk("alloc_tag", 32'(alloc_tag), 32'(m_tail % DEPTH));
      ec = reset_n && !flush && (m.size() > 0) && (m[0].ready || byp_hit());
      chk("commit_en", 32'(commit_en), 32'(ec));
      if (commit_en && ec) begin
         ed = byp_hit() ? wb_data : m[0].data;
         chk("commit_reg", 32'(commit_reg), 32'(m[0].dest));
         chk("commit_data", 32'(commit_data), 32'(ed));
      end
      if (commit_en) log_q.push_back('{commit_reg, commit_data});
   end

   task automatic cyc(input bit av, input logic [REG_AW-1:0] ad, input bit wv,
                      input logic [TAG_W-1:0] wt, input logic [DATA_W-1:0] wd, input bit fl);
      alloc_valid = av; alloc_dest = ad; wb_valid = wv; wb_tag = wt; wb_data = wd; flush = fl;
      @(posedge clk); #1;
      alloc_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, '0, 0);
   endtask

   initial begin
      logic [REG_AW-1:0] er[3];
      logic [DATA_W-1:0] ev[3];
      logic [DATA_W-1:0] wd_a[20];
      logic [TAG_W-1:0]  base;
      ent_t              snap[$];

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_empty", 32'(rob_empty), 32'd1);
      chk("rst_count", 32'(rob_count), 32'd0);
      chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);

      // Out-of-order writeback, in-order commit
      log_q.delete();
      cyc(1, 5'd3, 0, '0, '0, 0);
      cyc(1, 5'd5, 0, '0, '0, 0);
      cyc(1, 5'd7, 0, '0, '0, 0);
      cyc(0, '0, 1, 3'd2, 16'h00AA, 0);
      cyc(0, '0, 1, 3'd0, 16'h1111, 0);
      cyc(0, '0, 1, 3'd1, 16'h2222, 0);
      idle(4);
      er = '{5'd3, 5'd5, 5'd7};
      ev = '{16'h1111, 16'h2222, 16'h00AA};
      chk("ooo_commit_count", 32'(log_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < log_q.size(); i++) begin
         chk("ooo_commit_reg", 32'(log_q[i].r), 32'(er[i]));
         chk("ooo_commit_data", 32'(log_q[i].d), 32'(ev[i]));
      end

      // Fill to capacity, overflow alloc ignored, then release the head
      base = alloc_tag;
      for (int i = 0; i < 8; i++) cyc(1, 5'(10 + i), 0, '0, '0, 0);
      chk("full_flag", 32'(rob_full), 32'd1);
      chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(rob_count), 32'd8);
      cyc(1, 5'd31, 0, '0, '0, 0);
      chk("full_overflow_count", 32'(rob_count), 32'd8);
      cyc(0, '0, 1, base, 16'h0F0F, 0);
      chk("full_wb_commit_en", 32'(commit_en), 32'(!BYP));
      idle(1);
      chk("full_alloc_ready_after", 32'(alloc_ready), 32'd1);
      for (int i = 1; i < 8; i++) cyc(0, '0, 1, TAG_W'(base + TAG_W'(i)), 16'(i * 3), 0);
      idle(10);

      // Flush while head is ready
      base = alloc_tag;
      for (int i = 0; i < 4; i++) cyc(1, 5'(20 + i), 0, '0, '0, 0);
      cyc(0, '0, 1, TAG_W'(base + TAG_W'(2)), 16'h2020, 0);
      cyc(0, '0, 1, base, 16'h0101, 0);
      flush = 1'b1;
      #1 chk("flush_commit_en", 32'(commit_en), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_empty", 32'(rob_empty), 32'd1);
      chk("flush_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("flush_count", 32'(rob_count), 32'd0);

      // Wrap-around streaming
      log_q.delete();
      for (int i = 0; i < 20; i++) begin
         wd_a[i] = 16'($urandom);
         chk("wrap_alloc_tag", 32'(alloc_tag), 32'(i % 8));
         if (i == 0) cyc(1, 5'(i), 0, '0, '0, 0);
         else        cyc(1, 5'(i), 1, TAG_W'((i - 1) % 8), wd_a[i - 1], 0);
      end
      cyc(0, '0, 1, TAG_W'(19 % 8), wd_a[19], 0);
      idle(3);
      chk("wrap_commit_count", 32'(log_q.size()), 32'd20);
      for (int i = 0; i < 20 && i < log_q.size(); i++) begin
         chk("wrap_commit_reg", 32'(log_q[i].r), 32'(i));
         chk("wrap_commit_data", 32'(log_q[i].d), 32'(wd_a[i]));
      end

      // Writeback to head: same-cycle commit with bypass, next cycle without
      log_q.delete();
      cyc(1, 5'd9, 0, '0, '0, 0);
      idle(1);
      base = m[0].tag;
      wb_valid = 1'b1; wb_tag = base; wb_data = 16'hBEEF;
      #1 chk("byp_same_cycle_commit_en", 32'(commit_en), 32'(BYP));
      @(posedge clk); #1;
      wb_valid = 1'b0;
      chk("byp_next_cycle_commit_en", 32'(commit_en), 32'(!BYP));
      idle(2);
      chk("byp_commit_count", 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
         chk("byp_commit_reg", 32'(log_q[0].r), 32'd9);
         chk("byp_commit_data", 32'(log_q[0].d), 32'hBEEF);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit                wv;
         logic [TAG_W-1:0]  wt;
         wv = 1'b0; wt = '0;
         if (m.size() > 0 && $urandom_range(9, 0) < 7) begin
            wv = 1'b1;
            wt = m[$urandom_range(m.size() - 1, 0)].tag;
         end else if ($urandom_range(9, 0) == 0) begin
            wv = 1'b1;
            wt = TAG_W'($urandom);
         end
         cyc($urandom_range(9, 0) < 6, REG_AW'($urandom), wv, wt, DATA_W'($urandom),
             $urandom_range(49, 0) == 0);
      end

      // Reset asserted in the middle of traffic
      alloc_valid = 1'b1; alloc_dest = 5'd17; wb_valid = 1'b1; wb_tag = '0; wb_data = 16'h5555;
      reset_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      alloc_valid = 1'b0; wb_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      chk("midrst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("midrst_empty", 32'(rob_empty), 32'd1);
      chk("midrst_count", 32'(rob_count), 32'd0);
      chk("midrst_commit_en", 32'(commit_en), 32'd0);
      chk("midrst_alloc_tag", 32'(alloc_tag), 32'd0);

      for (int i = 0; i < 60; i++)
         cyc($urandom_range(1, 0) == 1, REG_AW'($urandom), m.size() > 0,
             (m.size() > 0) ? m[$urandom_range(m.size() - 1, 0)].tag : '0, DATA_W'($urandom), 0);
      snap = m;
      foreach (snap[i]) cyc(0, '0, 1, snap[i].tag, DATA_W'($urandom), 0);
      idle(10);
      chk("drain_empty", 32'(rob_empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
